// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a direct-mapped, write-back, write-allocate cache.
// Holds the tag/valid/dirty store, serves one CPU access at a time, runs the
// RAM writeback/fill handshake and drives the line datapath selects.
module cache_ctrl_fsm #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 4,
  parameter int B_VAL_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IN_CPU_REQ,
  input  logic                IN_CPU_WR,
  input  logic [ADDR_W-1:0]   IN_CPU_ADDR,
  input  logic [B_VAL_W-1:0]  IN_B_VAL,
  output logic                OUT_CPU_BUSY,
  output logic                OUT_CPU_DONE,
  output logic                OUT_RAM_REQ,
  output logic                OUT_RAM_WR,
  output logic [ADDR_W-1:0]   OUT_RAM_ADDR,
  input  logic                IN_RAM_ACK,
  output logic                OUT_SIG_RAM_LOAD,
  output logic                OUT_WR_FLAG,
  output logic [B_VAL_W-1:0]  OUT_B_VAL,
  output logic [OFFSET_W-1:0] OUT_ADDR_OFFSET,
  output logic [INDEX_W-1:0]  OUT_CACHE_INDEX,
  output logic                OUT_CACHE_WE,
  output logic [CNT_W-1:0]    OUT_HIT_CNT,
  output logic [CNT_W-1:0]    OUT_MISS_CNT
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_RESP
  } state_t;

  state_t state, state_nxt;

  // latched request
  logic                wr_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic [B_VAL_W-1:0]  bval_q;

  // line bookkeeping; tags need no reset because valid gates every compare
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;

  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  logic hit;
  logic ram_ack;

  assign hit     = valid[idx_q] && (tag_mem[idx_q] == tag_q);
  // ACK only counts while a line transaction is actually requested
  assign ram_ack = IN_RAM_ACK && (state == S_WRITEBACK || state == S_FILL);

  // state register; reset aborts any transaction in flight
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // capture the access only when accepting it, so later input wiggles are ignored
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q   <= 1'b0;
      tag_q  <= '0;
      idx_q  <= '0;
      off_q  <= '0;
      bval_q <= '0;
    end else if (state == S_IDLE && IN_CPU_REQ) begin
      wr_q   <= IN_CPU_WR;
      tag_q  <= IN_CPU_ADDR[ADDR_W-1 -: TAG_W];
      idx_q  <= IN_CPU_ADDR[OFFSET_W +: INDEX_W];
      off_q  <= IN_CPU_ADDR[OFFSET_W-1:0];
      bval_q <= IN_B_VAL;
    end
  end

  // valid/dirty tracking: fill validates clean, writeback cleans, write hit dirties
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (state == S_WRITEBACK && ram_ack) dirty[idx_q] <= 1'b0;
      if (state == S_FILL && ram_ack) begin
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= 1'b0;
      end
      if (state == S_RESP && wr_q) dirty[idx_q] <= 1'b1;
    end
  end

  // tag is installed on the fill ACK, together with the line data
  always_ff @(posedge CLK) begin
    if (!RESET && state == S_FILL && ram_ack) tag_mem[idx_q] <= tag_q;
  end

  // saturating hit/miss statistics, decided once per access in LOOKUP
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // next state and datapath/RAM controls
  always_comb begin
    state_nxt        = state;
    OUT_CPU_DONE     = 1'b0;
    OUT_RAM_REQ      = 1'b0;
    OUT_RAM_WR       = 1'b0;
    OUT_RAM_ADDR     = '0;
    OUT_SIG_RAM_LOAD = 1'b0;
    OUT_WR_FLAG      = 1'b0;
    OUT_CACHE_WE     = 1'b0;
    case (state)
      S_IDLE: begin
        if (IN_CPU_REQ) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)                         state_nxt = S_RESP;
        else if (valid[idx_q] && dirty[idx_q]) state_nxt = S_WRITEBACK;
        else                             state_nxt = S_FILL;
      end
      S_WRITEBACK: begin
        // victim line goes out under its stored tag
        OUT_RAM_REQ  = 1'b1;
        OUT_RAM_WR   = 1'b1;
        OUT_RAM_ADDR = {tag_mem[idx_q], idx_q, {OFFSET_W{1'b0}}};
        if (ram_ack) state_nxt = S_FILL;
      end
      S_FILL: begin
        OUT_RAM_REQ  = 1'b1;
        OUT_RAM_ADDR = {tag_q, idx_q, {OFFSET_W{1'b0}}};
        if (ram_ack) begin
          // fill data is on the RAM bus only this cycle: write it straight in
          OUT_SIG_RAM_LOAD = 1'b1;
          OUT_CACHE_WE     = 1'b1;
          state_nxt        = S_RESP;
        end
      end
      S_RESP: begin
        OUT_CPU_DONE = 1'b1;
        OUT_CACHE_WE = wr_q;
        OUT_WR_FLAG  = wr_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign OUT_CPU_BUSY    = (state != S_IDLE);
  assign OUT_B_VAL       = bval_q;
  assign OUT_ADDR_OFFSET = off_q;
  assign OUT_CACHE_INDEX = idx_q;
  assign OUT_HIT_CNT     = hit_cnt;
  assign OUT_MISS_CNT    = miss_cnt;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: a line-level cache model predicts the
// RAM transactions and completions; a monitor checks them as they appear.
module tb_cache_ctrl_fsm;
  localparam int ADDR_W = 16, INDEX_W = 4, OFFSET_W = 4, B_VAL_W = 4, CNT_W = 4;

  logic CLK, RESET;
  logic IN_CPU_REQ, IN_CPU_WR, IN_RAM_ACK;
  logic [ADDR_W-1:0] IN_CPU_ADDR;
  logic [B_VAL_W-1:0] IN_B_VAL;
  logic OUT_CPU_BUSY, OUT_CPU_DONE, OUT_RAM_REQ, OUT_RAM_WR;
  logic [ADDR_W-1:0] OUT_RAM_ADDR;
  logic OUT_SIG_RAM_LOAD, OUT_WR_FLAG, OUT_CACHE_WE;
  logic [B_VAL_W-1:0] OUT_B_VAL;
  logic [OFFSET_W-1:0] OUT_ADDR_OFFSET;
  logic [INDEX_W-1:0] OUT_CACHE_INDEX;
  logic [CNT_W-1:0] OUT_HIT_CNT, OUT_MISS_CNT;

  cache_ctrl_fsm #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W),
                   .B_VAL_W(B_VAL_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_CPU_REQ(IN_CPU_REQ), .IN_CPU_WR(IN_CPU_WR), .IN_CPU_ADDR(IN_CPU_ADDR), .IN_B_VAL(IN_B_VAL),
    .OUT_CPU_BUSY(OUT_CPU_BUSY), .OUT_CPU_DONE(OUT_CPU_DONE),
    .OUT_RAM_REQ(OUT_RAM_REQ), .OUT_RAM_WR(OUT_RAM_WR), .OUT_RAM_ADDR(OUT_RAM_ADDR),
    .IN_RAM_ACK(IN_RAM_ACK), .OUT_SIG_RAM_LOAD(OUT_SIG_RAM_LOAD), .OUT_WR_FLAG(OUT_WR_FLAG),
    .OUT_B_VAL(OUT_B_VAL), .OUT_ADDR_OFFSET(OUT_ADDR_OFFSET), .OUT_CACHE_INDEX(OUT_CACHE_INDEX),
    .OUT_CACHE_WE(OUT_CACHE_WE), .OUT_HIT_CNT(OUT_HIT_CNT), .OUT_MISS_CNT(OUT_MISS_CNT)
  );

  // expected event: a RAM line transaction or a CPU completion
  typedef struct {
    bit         is_done;
    bit         wr;
    logic [15:0] addr;
    logic [3:0] idx;
    logic [3:0] off;
    logic [3:0] bval;
    logic [3:0] hc;
    logic [3:0] mc;
    bit         hit;
  } exp_t;

  exp_t sbq[$];

  int tests = 0, fails = 0;
  int cyc = 0, req_cyc = 0, last_ack = 0, done_cnt = 0;
  bit stray_en = 0;

  // behavioural cache model
  bit [7:0] m_tag [16];
  bit       m_valid [16];
  bit       m_dirty [16];
  int       m_hit, m_miss;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hit = 0;
    m_miss = 0;
  endtask

  // predict one access: optional victim writeback, fill, then completion
  task automatic model_access(input bit wr, input logic [15:0] a, input logic [3:0] bv);
    exp_t e;
    int idx, off;
    bit [7:0] tag;
    bit hit;
    tag = a[15:8];
    idx = int'(a[7:4]);
    off = int'(a[3:0]);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) begin
      if (m_hit < 15) m_hit++;
    end else begin
      if (m_miss < 15) m_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        e = '{is_done: 0, wr: 1, addr: {m_tag[idx], 8'h00} + 16'(idx * 16),
              idx: 4'(idx), off: 0, bval: 0, hc: 0, mc: 0, hit: 0};
        sbq.push_back(e);
      end
      e = '{is_done: 0, wr: 0, addr: a - 16'(off), idx: 4'(idx), off: 0, bval: 0,
            hc: 0, mc: 0, hit: 0};
      sbq.push_back(e);
      m_tag[idx] = tag;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    if (wr) m_dirty[idx] = 1;
    e = '{is_done: 1, wr: wr, addr: a, idx: 4'(idx), off: 4'(off), bval: bv,
          hc: 4'(m_hit), mc: 4'(m_miss), hit: hit};
    sbq.push_back(e);
  endtask

  // RAM responder: ACK after 0..3 wait cycles, optional stray ACKs when idle
  initial begin
    int wait_c, delay;
    IN_RAM_ACK = 0;
    wait_c = 0;
    delay = $urandom_range(0, 3);
    forever begin
      @(posedge CLK);
      #1;
      if (IN_RAM_ACK) begin
        IN_RAM_ACK = 0;
        wait_c = 0;
        delay = $urandom_range(0, 3);
      end else if (OUT_RAM_REQ) begin
        if (wait_c >= delay) IN_RAM_ACK = 1;
        else wait_c++;
      end else begin
        wait_c = 0;
        if (stray_en && $urandom_range(0, 3) == 0) IN_RAM_ACK = 1;
      end
    end
  end

  // monitor: compare every visible DUT event against the scoreboard head
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (OUT_RAM_REQ) begin
          if (sbq.size() == 0 || sbq[0].is_done) check("unexpected_ram_req", 1, 0);
          else begin
            check("ram_wr", OUT_RAM_WR, sbq[0].wr);
            check("ram_addr", OUT_RAM_ADDR, sbq[0].addr);
            if (IN_RAM_ACK) begin
              check("ack_load", OUT_SIG_RAM_LOAD, !sbq[0].wr);
              check("ack_we", OUT_CACHE_WE, !sbq[0].wr);
              check("ack_wr_flag", OUT_WR_FLAG, 0);
              check("ack_index", OUT_CACHE_INDEX, sbq[0].idx);
              last_ack = cyc;
              void'(sbq.pop_front());
            end else begin
              check("ram_wait_ctrl", {OUT_SIG_RAM_LOAD, OUT_CACHE_WE, OUT_WR_FLAG}, 0);
            end
          end
        end else if (OUT_CPU_DONE) begin
          if (sbq.size() == 0 || !sbq[0].is_done) check("unexpected_done", 1, 0);
          else begin
            check("done_busy", OUT_CPU_BUSY, 1);
            check("done_index", OUT_CACHE_INDEX, sbq[0].idx);
            check("done_offset", OUT_ADDR_OFFSET, sbq[0].off);
            check("done_we", OUT_CACHE_WE, sbq[0].wr);
            check("done_wr_flag", OUT_WR_FLAG, sbq[0].wr);
            check("done_load", OUT_SIG_RAM_LOAD, 0);
            if (sbq[0].wr) check("done_b_val", OUT_B_VAL, sbq[0].bval);
            check("hit_cnt", OUT_HIT_CNT, sbq[0].hc);
            check("miss_cnt", OUT_MISS_CNT, sbq[0].mc);
            if (sbq[0].hit) check("hit_latency", cyc - req_cyc, 2);
            else            check("miss_latency", cyc - last_ack, 1);
            void'(sbq.pop_front());
            done_cnt++;
          end
        end else if (OUT_CACHE_WE || OUT_WR_FLAG || OUT_SIG_RAM_LOAD) begin
          check("stray_ctrl", {OUT_SIG_RAM_LOAD, OUT_CACHE_WE, OUT_WR_FLAG}, 0);
        end
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return {OUT_CPU_BUSY, OUT_CPU_DONE, OUT_RAM_REQ, OUT_RAM_WR, OUT_RAM_ADDR,
            OUT_SIG_RAM_LOAD, OUT_WR_FLAG, OUT_B_VAL, OUT_ADDR_OFFSET,
            OUT_CACHE_INDEX, OUT_CACHE_WE, OUT_HIT_CNT, OUT_MISS_CNT};
  endfunction

  // one CPU access, entered just after a rising edge; hold keeps REQ high
  // (with scrambled inputs) for the whole busy period
  task automatic access(input bit wr, input logic [15:0] a, input logic [3:0] bv, input bit hold);
    int start;
    bit got;
    model_access(wr, a, bv);
    IN_CPU_REQ = 1;
    IN_CPU_WR = wr;
    IN_CPU_ADDR = a;
    IN_B_VAL = bv;
    req_cyc = cyc;
    start = done_cnt;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge CLK);
      #1;
      IN_CPU_ADDR = 16'($urandom);
      IN_CPU_WR = 1'($urandom);
      IN_B_VAL = 4'($urandom);
      if (done_cnt != start) begin
        got = 1;
        IN_CPU_REQ = 0;
      end else if (!hold) IN_CPU_REQ = 0;
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      IN_CPU_REQ = 0;
    end
  endtask

  initial begin
    bit found;
    RESET = 1;
    IN_CPU_REQ = 0;
    IN_CPU_WR = 0;
    IN_CPU_ADDR = 0;
    IN_B_VAL = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", all_outs(), 0);
    RESET = 0;
    @(posedge CLK);
    #1;

    // cold miss, hit on the same line, write hit, dirty-victim miss
    access(0, 16'h1234, 4'h0, 0);
    access(0, 16'h1238, 4'h0, 0);
    access(1, 16'h1234, 4'b0011, 0);
    access(0, 16'h5630, 4'h0, 0);

    // reset while filling, with REQ still asserted
    model_access(0, 16'h9930, 4'h0);
    IN_CPU_REQ = 1;
    IN_CPU_WR = 0;
    IN_CPU_ADDR = 16'h9930;
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(posedge CLK);
      #1;
      if (OUT_RAM_REQ && !OUT_RAM_WR) found = 1;
    end
    if (!found) check("fill_timeout", 0, 1);
    RESET = 1;
    @(posedge CLK);
    #1;
    check("midop_reset_outputs", all_outs(), 0);
    RESET = 0;
    IN_CPU_REQ = 0;
    sbq.delete();
    model_reset();
    @(posedge CLK);
    #1;
    access(0, 16'h5630, 4'h0, 0);

    // counter saturation at 4 bits
    for (int i = 0; i < 20; i++) access(0, 16'h5638, 4'h0, 1'(i % 2));

    // randomized traffic with stray ACKs and held requests
    stray_en = 1;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = {8'($urandom_range(0, 2)), 4'($urandom_range(0, 7)), 4'($urandom)};
      access(1'($urandom), a, 4'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (10) @(posedge CLK);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    check("final_idle", OUT_CPU_BUSY, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
